// File: rtl/apb_seq_pkg.sv
// Shared types and register map for the APB transfer sequencer.
// The state enum, beat index type and slave register offsets live here.
package apb_seq_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, ACCESS, DONE} seq_state_e;

    typedef logic [1:0] beat_t;

    localparam logic [31:0] REG_DEST  = 32'h0000_0000;
    localparam logic [31:0] REG_CMD   = 32'h0000_0004;
    localparam logic [31:0] REG_DATA  = 32'h0000_0008;
    localparam logic [31:0] REG_START = 32'h0000_000C;

    function automatic logic [31:0] beat_offset(input beat_t beat);
        logic [31:0] off;
        unique case (beat)
            2'd0:    off = REG_DEST;
            2'd1:    off = REG_CMD;
            2'd2:    off = REG_DATA;
            default: off = REG_START;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the granted requester whenever advance_i is high.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [2:0]       grant_idx_o
);

    logic [2:0]  ptr_q, ptr_d;
    logic [15:0] req_pad;
    logic [15:0] gnt_pad;
    logic [3:0]  j;
    logic [3:0]  nxt;
    logic        found;

    assign req_pad = 16'(req_i);
    assign grant_o = gnt_pad[N_REQ-1:0];

    always_comb begin
        gnt_pad     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Scan starting at the pointer, wrapping at N_REQ.
            j = {1'b0, ptr_q} + 4'(k);
            if (j >= 4'(N_REQ)) begin
                j = j - 4'(N_REQ);
            end
            if (!found && req_pad[j]) begin
                found       = 1'b1;
                gnt_pad[j]  = 1'b1;
                grant_idx_o = j[2:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        nxt   = {1'b0, grant_idx_o} + 4'd1;
        if (advance_i && found) begin
            ptr_d = (nxt >= 4'(N_REQ)) ? 3'd0 : nxt[2:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_txn_sequencer.sv
// APB master sharing a 4-register transfer slave between N_REQ requesters.
// Each granted request becomes DEST, CMD, DATA and START writes in order.
module apb_txn_sequencer
    import apb_seq_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] START_WORD = 32'h0000_0001,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_dest,
    input  logic [32*N_REQ-1:0] req_cmd,
    input  logic [32*N_REQ-1:0] req_data,
    output logic                done,
    output logic [2:0]          done_id,
    output logic                done_err,
    output logic                busy,
    output logic [31:0]         PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PWDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    beat_t             beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       dest_q, dest_d, cmd_q, cmd_d, data_q, data_d;
    logic [N_REQ-1:0]  grant;
    logic [2:0]        grant_idx;
    logic [31:0]       word;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .req_i      (req_valid),
        .advance_i  (state_q == GRANT),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        idx_d   = idx_q;
        dest_d  = dest_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) state_d = GRANT;
            end
            GRANT: begin
                // A requester may have withdrawn since IDLE; fall back if nobody is left.
                if (|grant) begin
                    idx_d   = grant_idx;
                    beat_d  = '0;
                    state_d = SETUP;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            dest_d = req_dest[i*32 +: 32];
                            cmd_d  = req_cmd[i*32 +: 32];
                            data_d = req_data[i*32 +: 32];
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                tmo_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (beat_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = SETUP;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (tmo_q != {TW{1'b1}}) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dest_q  <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            dest_q  <= dest_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        unique case (beat_q)
            2'd0:    word = dest_q;
            2'd1:    word = cmd_q;
            2'd2:    word = data_q;
            default: word = START_WORD;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        req_ready = (state_q == GRANT) ? grant : '0;
        PSEL      = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE   = (state_q == ACCESS);
        PWRITE    = PSEL;
        PADDR     = PSEL ? (BASE_ADDR + beat_offset(beat_q)) : '0;
        PWDATA    = PSEL ? word : '0;
        done      = (state_q == DONE);
        done_id   = done ? idx_q : '0;
        done_err  = done ? err_q : 1'b0;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_apb_txn_sequencer.sv
// Self-checking bench for apb_txn_sequencer: a reactive APB slave with per-beat
// wait/error plans, a write monitor, and a request-level reference model.
module tb_apb_txn_sequencer;

    localparam int unsigned N_REQ      = 4;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
    localparam logic [31:0] START_WORD = 32'h0000_0001;
    localparam int unsigned TIMEOUT    = 16;

    logic                PCLK = 1'b0;
    logic                PRESET = 1'b1;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_dest = '0, req_cmd = '0, req_data = '0;
    logic                done, done_err, busy;
    logic [2:0]          done_id;
    logic [31:0]         PADDR, PWDATA;
    logic                PSEL, PENABLE, PWRITE;
    logic                PREADY = 1'b1, PSLVERR = 1'b0;

    apb_txn_sequencer #(
        .N_REQ(N_REQ), .BASE_ADDR(BASE_ADDR), .START_WORD(START_WORD), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_cmd(req_cmd), .req_data(req_data), .done(done),
        .done_id(done_id), .done_err(done_err), .busy(busy), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } wr_t;

    wr_t         wr_q[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, rdy_cnt = 0, done_cnt = 0, waited = 0;
    int          wait_plan[4];
    bit          err_plan[4];
    int          ptr = 0, cur_id = 0, t0 = 0;
    logic [31:0] w_dest[N_REQ], w_cmd[N_REQ], w_data[N_REQ];
    logic [31:0] e_words[4];
    logic [31:0] setup_addr = '0, setup_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave: hold PREADY low for the planned number of ACCESS cycles, then complete.
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                if (waited < wait_plan[PADDR[3:2]]) begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'b0;
                    waited++;
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = err_plan[PADDR[3:2]];
                end
            end else begin
                waited  = 0;
                PREADY  = 1'b1;
                PSLVERR = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge PCLK);
            if (req_ready != '0) rdy_cnt++;
            if (done) done_cnt++;
            if (PSEL) check_eq("pwrite", 32'(PWRITE), 32'd1);
            if (PSEL && !PENABLE) begin
                setup_addr = PADDR;
                setup_data = PWDATA;
            end
            if (PSEL && PENABLE) begin
                check_eq("hold_addr", PADDR, setup_addr);
                check_eq("hold_data", PWDATA, setup_data);
                if (PREADY) wr_q.push_back(wr_t'{PADDR, PWDATA, PSLVERR});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] c,
                           input logic [31:0] x);
        w_dest[i] = d;
        w_cmd[i]  = c;
        w_data[i] = x;
        req_dest[i*32 +: 32] = d;
        req_cmd[i*32 +: 32]  = c;
        req_data[i*32 +: 32] = x;
        req_valid[i] = 1'b1;
    endtask

    task automatic clean_plan();
        for (int k = 0; k < 4; k++) begin
            wait_plan[k] = 0;
            err_plan[k]  = 1'b0;
        end
    endtask

    task automatic rand_plan();
        for (int k = 0; k < 4; k++) begin
            int r;
            r = int'($urandom_range(0, 24));
            wait_plan[k] = (r == 0) ? int'(TIMEOUT + $urandom_range(0, 3)) :
                           (r < 6) ? int'($urandom_range(1, 3)) : 0;
            err_plan[k] = ($urandom_range(0, 19) == 0);
        end
    endtask

    task automatic grant_phase(input bit hold);
        int exp_id;
        bit got;
        exp_id = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (ptr + k) % N_REQ;
            if (exp_id < 0 && req_valid[j]) exp_id = j;
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            got = (req_ready != '0);
        end
        check_eq("grant_seen", 32'(got), 32'd1);
        if (!got || exp_id < 0) return;
        rdy_cnt = 0;
        check_eq("grant_onehot", 32'(req_ready), 32'd1 << exp_id);
        check_eq("busy_grant", 32'(busy), 32'd1);
        cur_id = exp_id;
        ptr = (exp_id + 1) % N_REQ;
        e_words[0] = w_dest[exp_id];
        e_words[1] = w_cmd[exp_id];
        e_words[2] = w_data[exp_id];
        e_words[3] = START_WORD;
        wr_q.delete();
        t0 = cyc;
        tick();
        // Request is accepted now; later input changes must not reach the bus.
        if (!hold) begin
            req_valid[exp_id] = 1'b0;
            req_dest[exp_id*32 +: 32] = ~e_words[0];
            req_cmd[exp_id*32 +: 32]  = $urandom();
            req_data[exp_id*32 +: 32] = $urandom();
        end
    endtask

    task automatic done_phase();
        wr_t exp_q[$];
        bit  exp_err;
        int  lat;
        exp_err = 1'b0;
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            if (wait_plan[k] >= int'(TIMEOUT)) begin
                exp_err = 1'b1;
                lat += 1 + int'(TIMEOUT);
                break;
            end
            exp_q.push_back(wr_t'{BASE_ADDR + 32'(4 * k), e_words[k], err_plan[k]});
            lat += 2 + wait_plan[k];
            if (err_plan[k]) begin
                exp_err = 1'b1;
                break;
            end
        end
        for (int c = 0; c < 200 && !done; c++) tick();
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("done_id", 32'(done_id), 32'(cur_id));
        check_eq("done_err", 32'(done_err), 32'(exp_err));
        check_eq("latency", 32'(cyc - t0), 32'(lat));
        check_eq("ready_pulses", 32'(rdy_cnt), 32'd1);
        check_eq("n_writes", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check_eq("wr_addr", wr_q[i].addr, exp_q[i].addr);
            check_eq("wr_data", wr_q[i].data, exp_q[i].data);
            check_eq("wr_err", 32'(wr_q[i].err), 32'(exp_q[i].err));
        end
    endtask

    initial begin
        int dc;
        bit hit;
        clean_plan();
        #1;
        check_eq("rst_psel", 32'(PSEL), 32'd0);
        check_eq("rst_penable", 32'(PENABLE), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_paddr", PADDR, 32'd0);
        repeat (3) @(posedge PCLK);
        #2;
        PRESET = 1'b0;

        // All four held valid: strict round-robin 0,1,2,3,0.
        for (int i = 0; i < N_REQ; i++) set_req(i, 32'h100 + i, 32'h200 + i, 32'h300 + i);
        for (int s = 0; s < 5; s++) begin
            grant_phase(1'b1);
            if (s == 4) req_valid = '0;
            done_phase();
        end

        set_req(0, 32'd6, 32'd20102025, 32'd75799072);
        grant_phase(1'b0);
        done_phase();

        set_req(1, 32'hA1, 32'hB1, 32'hC1);
        wait_plan[2] = 3;
        grant_phase(1'b0);
        done_phase();

        clean_plan();
        err_plan[1] = 1'b1;
        set_req(2, 32'hA2, 32'hB2, 32'hC2);
        grant_phase(1'b0);
        done_phase();
        clean_plan();
        set_req(3, 32'hA3, 32'hB3, 32'hC3);
        grant_phase(1'b0);
        done_phase();

        wait_plan[0] = int'(TIMEOUT) + 4;
        set_req(0, 32'hA0, 32'hB0, 32'hC0);
        grant_phase(1'b0);
        done_phase();
        check_eq("tmo_psel", 32'(PSEL), 32'd0);
        tick();
        check_eq("tmo_idle", 32'(busy), 32'd0);

        // Reset in the middle of the START beat.
        clean_plan();
        wait_plan[3] = 6;
        set_req(2, 32'hD2, 32'hE2, 32'hF2);
        grant_phase(1'b0);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            tick();
            hit = PSEL && PENABLE && (PADDR == BASE_ADDR + 32'hC);
        end
        check_eq("beat3_reached", 32'(hit), 32'd1);
        dc = done_cnt;
        PRESET = 1'b1;
        #1;
        check_eq("mid_rst_psel", 32'(PSEL), 32'd0);
        check_eq("mid_rst_penable", 32'(PENABLE), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        PRESET = 1'b0;
        check_eq("post_rst_idle", 32'(busy), 32'd0);
        check_eq("no_done_pulse", 32'(done_cnt), 32'(dc));
        ptr = 0;
        clean_plan();
        set_req(0, 32'h10, 32'h20, 32'h30);
        set_req(3, 32'h13, 32'h23, 32'h33);
        grant_phase(1'b0);
        done_phase();
        grant_phase(1'b0);
        done_phase();

        for (int it = 0; it < 25; it++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < N_REQ; i++) begin
                if (m[i]) set_req(i, $urandom(), $urandom(), $urandom());
            end
            for (int s = 0; s < $countones(m); s++) begin
                rand_plan();
                grant_phase(1'b0);
                done_phase();
            end
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
